// File: rtl/pack_tx.sv
// Datapack transmitter: a sample RAM filled through a write port and replayed on start
// as one valid/ready/last pack, with sample 0 sent first.
module pack_tx #(
    parameter int G_BIT_WIDTH = 32,
    parameter int G_CNT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_en,
    input  logic [G_CNT_WIDTH-1:0] i_wr_addr,
    input  logic [G_BIT_WIDTH-1:0] i_wr_data,
    input  logic                   i_start,
    input  logic [G_CNT_WIDTH-1:0] i_len_m1,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [G_BIT_WIDTH-1:0] o_data,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_dbg_state
);
    localparam int DEPTH = 2 ** G_CNT_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state;
    logic [G_BIT_WIDTH-1:0] mem [DEPTH];
    logic [G_CNT_WIDTH-1:0] len;
    logic [G_CNT_WIDTH-1:0] rd_addr;
    logic [G_CNT_WIDTH-1:0] rd_ptr;
    logic                   rd_all;
    logic                   rd_en;
    logic                   rd_is_last;
    logic                   rd_vld;
    logic                   rd_last;
    logic [G_BIT_WIDTH-1:0] rd_q;
    logic                   sk_vld;
    logic                   sk_last;
    logic [G_BIT_WIDTH-1:0] sk_q;
    logic                   xfer;
    logic                   head_free;
    logic [1:0]             occ;
    logic                   room;

    // Handshake: a beat moves when o_valid & i_ready. While stalled, o_valid/o_data/o_last
    // hold. A read is issued only when output register + skid can absorb its data.
    always_comb begin
        xfer       = o_valid & i_ready;
        head_free  = ~o_valid | i_ready;
        occ        = {1'b0, o_valid} + {1'b0, sk_vld} + {1'b0, rd_vld};
        room       = (occ <= ({1'b0, xfer} + 2'd1));
        rd_ptr     = (state == IDLE) ? '0 : rd_addr;
        rd_is_last = (state == IDLE) ? (i_len_m1 == '0) : (rd_addr == len);
        rd_en      = (state == IDLE) ? i_start : (~rd_all & room);
    end

    assign o_dbg_state = (state == SEND);

    // RAM is never reset; a same-cycle write at the read address yields the old word.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
        if (rd_en)   rd_q <= mem[rd_ptr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            len     <= '0;
            rd_addr <= '0;
            rd_all  <= 1'b0;
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
            sk_vld  <= 1'b0;
            sk_last <= 1'b0;
            sk_q    <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            rd_vld <= rd_en;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= SEND;
                        len    <= i_len_m1;
                        rd_all <= 1'b0;
                        o_busy <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer && o_last) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Address stops at the final index instead of incrementing, so full depth never wraps.
            if (rd_en) begin
                rd_last <= rd_is_last;
                if (rd_is_last) rd_all  <= 1'b1;
                else            rd_addr <= rd_ptr + 1'b1;
            end

            if (head_free) begin
                if (sk_vld) begin
                    o_valid <= 1'b1;
                    o_data  <= sk_q;
                    o_last  <= sk_last;
                    sk_vld  <= rd_vld;
                    sk_q    <= rd_q;
                    sk_last <= rd_last;
                end else if (rd_vld) begin
                    o_valid <= 1'b1;
                    o_data  <= rd_q;
                    o_last  <= rd_last;
                end else begin
                    o_valid <= 1'b0;
                end
            end else if (rd_vld) begin
                sk_vld  <= 1'b1;
                sk_q    <= rd_q;
                sk_last <= rd_last;
            end
        end
    end
endmodule

// File: tb/tb_pack_tx.sv
// Directed bench for pack_tx: scoreboard of expected beats plus cycle-exact timing checks.
module tb_pack_tx;
    localparam int BW = 32;
    localparam int CW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_wr_en = 1'b0;
    logic [CW-1:0] i_wr_addr = '0;
    logic [BW-1:0] i_wr_data = '0;
    logic          i_start = 1'b0;
    logic [CW-1:0] i_len_m1 = '0;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [BW-1:0] o_data;
    logic          o_last;
    logic          o_busy;
    logic          o_done;
    logic          o_dbg_state;

    logic [BW:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    pack_tx #(.G_BIT_WIDTH(BW), .G_CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_start(i_start), .i_len_m1(i_len_m1), .i_ready(i_ready),
        .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_busy(o_busy),
        .o_done(o_done), .o_dbg_state(o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [BW-1:0] data);
        i_wr_en   = 1'b1;
        i_wr_addr = addr[CW-1:0];
        i_wr_data = data;
        tick();
        i_wr_en   = 1'b0;
    endtask

    task automatic start_pack(input int len_m1);
        i_start  = 1'b1;
        i_len_m1 = len_m1[CW-1:0];
        tick();
        i_start  = 1'b0;
    endtask

    task automatic push_exp(input logic [BW-1:0] data, input logic last);
        exp_q.push_back({last, data});
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!o_done && n < max_cycles) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, o_done}, 32'd1);
    endtask

    // Monitor: every transfer is popped against the scoreboard; stalled beats must hold.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, o_valid}, 32'd1);
                check("stall_data", o_data, prev_data);
                check("stall_last", {31'd0, o_last}, {31'd0, prev_last});
            end
            if (o_done) done_cnt++;
            if (o_valid && i_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_beat", o_data, 32'hDEAD_BEEF);
                end else begin
                    logic [BW:0] e;
                    e = exp_q.pop_front();
                    check("beat_data", o_data, e[BW-1:0]);
                    check("beat_last", {31'd0, o_last}, {31'd0, e[BW]});
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
        end
    end

    initial begin
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        int b0;
        int d0;

        // Reset state
        #12;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_last", {31'd0, o_last}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // 1: four samples, ready held high, cycle-exact timing
        wr(0, 32'd5); wr(1, -32'sd3); wr(2, 32'd9); wr(3, 32'd2);
        push_exp(32'd5, 0); push_exp(-32'sd3, 0); push_exp(32'd9, 0); push_exp(32'd2, 1);
        i_ready = 1'b1;
        start_pack(3);
        check("t1_n1_valid", {31'd0, o_valid}, 32'd0);
        check("t1_n1_busy", {31'd0, o_busy}, 32'd1);
        tick();
        check("t1_n2_valid", {31'd0, o_valid}, 32'd1);
        check("t1_n2_data", o_data, 32'd5);
        check("t1_n2_last", {31'd0, o_last}, 32'd0);
        tick();
        check("t1_n3_data", o_data, 32'hFFFF_FFFD);
        tick();
        check("t1_n4_data", o_data, 32'd9);
        tick();
        check("t1_n5_data", o_data, 32'd2);
        check("t1_n5_last", {31'd0, o_last}, 32'd1);
        tick();
        check("t1_n6_done", {31'd0, o_done}, 32'd1);
        check("t1_n6_busy", {31'd0, o_busy}, 32'd0);
        check("t1_n6_valid", {31'd0, o_valid}, 32'd0);
        tick();
        check("t1_n7_done", {31'd0, o_done}, 32'd0);

        // 2: same pack under a stall pattern
        push_exp(32'd5, 0); push_exp(-32'sd3, 0); push_exp(32'd9, 0); push_exp(32'd2, 1);
        d0 = done_cnt;
        start_pack(3);
        for (int i = 0; i < 200; i++) begin
            i_ready = (i < 7) ? pat[i][0] : 1'b1;
            tick();
            if (o_done) break;
        end
        check("t2_done", {31'd0, o_done}, 32'd1);
        i_ready = 1'b1;
        tick();
        check("t2_done_cnt", d0 + 1, done_cnt);

        // 3: single beat, then back-to-back start in the done cycle with a same-cycle write
        wr(0, 32'hFFFF_FFFF);
        push_exp(32'hFFFF_FFFF, 1);
        start_pack(0);
        tick();
        check("t3_valid", {31'd0, o_valid}, 32'd1);
        check("t3_data", o_data, 32'hFFFF_FFFF);
        check("t3_last", {31'd0, o_last}, 32'd1);
        tick();
        check("t3_done", {31'd0, o_done}, 32'd1);
        push_exp(32'hFFFF_FFFF, 1);
        i_wr_en = 1'b1; i_wr_addr = '0; i_wr_data = 32'd7;
        start_pack(0);
        i_wr_en = 1'b0;
        tick();
        check("t3b_valid", {31'd0, o_valid}, 32'd1);
        check("t3b_data", o_data, 32'hFFFF_FFFF);
        wait_done(20);
        tick();
        push_exp(32'd7, 1);
        start_pack(0);
        wait_done(20);
        tick();

        // 4: full depth with random ready
        for (int k = 0; k < 256; k++) wr(k, k);
        for (int k = 0; k < 256; k++) push_exp(k, k == 255);
        b0 = beat_cnt;
        start_pack(255);
        for (int i = 0; i < 3000; i++) begin
            i_ready = 1'($urandom_range(0, 1));
            tick();
            if (o_done) break;
        end
        check("t4_done", {31'd0, o_done}, 32'd1);
        i_ready = 1'b1;
        tick();
        check("t4_beats", beat_cnt - b0, 32'd256);

        // 5a: start pulses during SEND are ignored; write ahead of the read pointer is sent
        for (int k = 0; k < 8; k++) push_exp((k == 6) ? 100 : k, k == 7);
        b0 = beat_cnt;
        d0 = done_cnt;
        start_pack(7);
        i_wr_en = 1'b1; i_wr_addr = 8'd6; i_wr_data = 32'd100;
        i_start = 1'b1; i_len_m1 = 8'd2;
        tick();
        i_wr_en = 1'b0;
        tick();
        i_start = 1'b0;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done(50);
        for (int i = 0; i < 12; i++) tick();
        check("t5_beats", beat_cnt - b0, 32'd8);
        check("t5_dones", done_cnt - d0, 32'd1);
        check("t5_idle_valid", {31'd0, o_valid}, 32'd0);
        wr(6, 32'd6);

        // 5b: reset mid-pack, then a fresh pack from address 0 with RAM intact
        for (int k = 0; k < 8; k++) push_exp(k, k == 7);
        start_pack(7);
        for (int i = 0; i < 30; i++) begin
            if (o_valid && o_data == 32'd2) break;
            tick();
        end
        check("t5_at_beat2", o_data, 32'd2);
        d0 = done_cnt;
        i_rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, o_valid}, 32'd0);
        check("t5_rst_busy", {31'd0, o_busy}, 32'd0);
        check("t5_rst_last", {31'd0, o_last}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        i_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_done", done_cnt - d0, 32'd0);
        check("t5_post_valid", {31'd0, o_valid}, 32'd0);
        for (int k = 0; k < 4; k++) push_exp(k, k == 3);
        start_pack(3);
        tick();
        check("t5_restart_data", o_data, 32'd0);
        wait_done(50);
        tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
